// File: rtl/tl_pkg.sv
// Shared light encodings, state set and phase-order helpers for the intersection scheduler.
// Build option TL_ALLRED_EN adds an all-red clearance state and widens the state index to 4 bits.
package tl_pkg;

    localparam logic [1:0] GREEN  = 2'b00;
    localparam logic [1:0] YELLOW = 2'b01;
    localparam logic [1:0] RED    = 2'b10;

`ifdef TL_ALLRED_EN
    localparam int ST_W = 4;
    typedef enum logic [ST_W-1:0] {
        A_GO   = 4'd0, A_YEL  = 4'd1, AL_GO  = 4'd2, AL_YEL = 4'd3,
        B_GO   = 4'd4, B_YEL  = 4'd5, BL_GO  = 4'd6, BL_YEL = 4'd7,
        ALLRED = 4'd8
    } state_e;
`else
    localparam int ST_W = 3;
    typedef enum logic [ST_W-1:0] {
        A_GO   = 3'd0, A_YEL  = 3'd1, AL_GO  = 3'd2, AL_YEL = 3'd3,
        B_GO   = 3'd4, B_YEL  = 3'd5, BL_GO  = 3'd6, BL_YEL = 3'd7
    } state_e;
`endif

    // Left-turn phases are skipped when nobody is waiting; through phases never are.
    function automatic state_e next_go(input state_e from_yel, input logic pend_al,
                                       input logic pend_bl);
        state_e nxt;
        case (from_yel)
            A_YEL:   nxt = pend_al ? AL_GO : B_GO;
            AL_YEL:  nxt = B_GO;
            B_YEL:   nxt = pend_bl ? BL_GO : A_GO;
            default: nxt = A_GO;
        endcase
        return nxt;
    endfunction

    function automatic logic is_go(input state_e s);
        return s inside {A_GO, AL_GO, B_GO, BL_GO};
    endfunction

    // State index bits [ST_W-1:1] name the approach, bit 0 selects yellow.
    function automatic logic [1:0] light_of(input state_e s, input logic [1:0] grp);
        logic [ST_W-1:0] sv;
        sv = s;
        if (sv[ST_W-1:1] == (ST_W-1)'(grp))
            return sv[0] ? YELLOW : GREEN;
        return RED;
    endfunction

endpackage

// File: rtl/tl_dwell_timer.sv
// Saturating dwell counter for the phase scheduler, with threshold flags on the next-tick value.
// Identical under TL_ALLRED_EN; the all-red dwell needs no compare of its own.
module tl_dwell_timer #(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int CNT_W     = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic tick_i,
    input  logic clr_i,
    output logic ge_min_o,
    output logic ge_max_o,
    output logic yel_done_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;

    // Compares use t+1 so a phase ends on the tick that completes its dwell.
    assign cnt_inc    = {1'b0, cnt_q} + (CNT_W+1)'(1);
    assign ge_min_o   = cnt_inc >= (CNT_W+1)'(GREEN_MIN);
    assign ge_max_o   = cnt_inc >= (CNT_W+1)'(GREEN_MAX);
    assign yel_done_o = cnt_inc == (CNT_W+1)'(YELLOW_T);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (tick_i && cnt_inc <= (CNT_W+1)'(GREEN_MAX))
            cnt_d = cnt_inc[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tl_phase_sched.sv
// Two-road intersection phase scheduler with demand-skipped protected left arrows.
// Defining TL_ALLRED_EN inserts a one-tick all-red state after every yellow.
module tl_phase_sched
    import tl_pkg::*;
#(
    parameter int GREEN_MIN = 8,
    parameter int GREEN_MAX = 30,
    parameter int YELLOW_T  = 3,
    parameter int CNT_W     = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            Ta,
    input  logic            Tal,
    input  logic            Tb,
    input  logic            Tbl,
    output logic [1:0]      La,
    output logic [1:0]      Lal,
    output logic [1:0]      Lb,
    output logic [1:0]      Lbl,
    output logic [ST_W-1:0] phase
);

    state_e     state_q, state_d;
    logic [3:0] pend_q, pend_d;
    logic [3:0] sens, own_bit, enter_bit;
    logic [1:0] grp;
    logic       other, own;
    logic       ge_min, ge_max, yel_done;
`ifdef TL_ALLRED_EN
    state_e     src_q, src_d;
`endif

    // Bit order of sens/pend: 0=A, 1=AL, 2=B, 3=BL, matching the state index pairs.
    assign sens    = {Tbl, Tb, Tal, Ta};
    assign grp     = state_q[2:1];
    assign own_bit = 4'b0001 << grp;
    assign other   = |(pend_q & ~own_bit);
    assign own     = |(sens & own_bit);

    tl_dwell_timer #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .CNT_W     (CNT_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .tick_i     (tick),
        .clr_i      (state_d != state_q),
        .ge_min_o   (ge_min),
        .ge_max_o   (ge_max),
        .yel_done_o (yel_done)
    );

    always_comb begin
        state_d = state_q;
`ifdef TL_ALLRED_EN
        src_d   = src_q;
`endif
        if (tick) begin
            case (state_q)
                A_GO, AL_GO, B_GO, BL_GO:
                    if (other && ((ge_min && !own) || ge_max))
                        state_d = state_e'({state_q[ST_W-1:1], 1'b1});
                A_YEL, AL_YEL, B_YEL, BL_YEL:
                    if (yel_done) begin
`ifdef TL_ALLRED_EN
                        src_d   = state_q;
                        state_d = ALLRED;
`else
                        state_d = next_go(state_q, pend_q[1], pend_q[3]);
`endif
                    end
`ifdef TL_ALLRED_EN
                ALLRED:  state_d = next_go(src_q, pend_q[1], pend_q[3]);
`endif
                default: state_d = A_GO;
            endcase
        end
    end

    // Entering a green consumes its demand, even if the sensor is still active.
    assign enter_bit = (state_d != state_q && is_go(state_d)) ? (4'b0001 << state_d[2:1]) : 4'b0000;
    assign pend_d    = (pend_q | sens) & ~enter_bit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= A_GO;
            pend_q  <= '0;
            La      <= GREEN;
            Lal     <= RED;
            Lb      <= RED;
            Lbl     <= RED;
`ifdef TL_ALLRED_EN
            src_q   <= A_YEL;
`endif
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            La      <= light_of(state_d, 2'd0);
            Lal     <= light_of(state_d, 2'd1);
            Lb      <= light_of(state_d, 2'd2);
            Lbl     <= light_of(state_d, 2'd3);
`ifdef TL_ALLRED_EN
            src_q   <= src_d;
`endif
        end
    end

    assign phase = state_q;

endmodule

// File: tb/tb_tl_phase_sched.sv
// Directed scenarios plus randomized traffic, checked against a behavioural intersection model.
// Follows TL_ALLRED_EN the same way the design does.
module tb_tl_phase_sched;

    localparam int GMIN = 8;
    localparam int GMAX = 30;
    localparam int YT   = 3;
`ifdef TL_ALLRED_EN
    localparam int AR_EN = 1;
    localparam int PW    = 4;
`else
    localparam int AR_EN = 0;
    localparam int PW    = 3;
`endif

    logic          clk = 1'b0;
    logic          reset, tick, Ta, Tal, Tb, Tbl;
    logic [1:0]    La, Lal, Lb, Lbl;
    logic [PW-1:0] phase;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    tl_phase_sched dut (
        .clk   (clk),
        .reset (reset),
        .tick  (tick),
        .Ta    (Ta),
        .Tal   (Tal),
        .Tb    (Tb),
        .Tbl   (Tbl),
        .La    (La),
        .Lal   (Lal),
        .Lb    (Lb),
        .Lbl   (Lbl),
        .phase (phase)
    );

    // Model: which approach holds the right of way, whether it is yellow or all-red,
    // dwell ticks so far, and outstanding demand per approach (0=A,1=AL,2=B,3=BL).
    int m_grp;
    bit m_yel, m_ar;
    int m_t;
    bit m_pend[4];
    bit seen_ar;

    function automatic int next_grp(int from);
        int g;
        g = (from + 1) % 4;
        if ((g == 1 || g == 3) && !m_pend[g]) g = (g + 1) % 4;
        return g;
    endfunction

    task automatic model_step(bit rst, bit tk, bit [3:0] s);
        bit changed, entered, other;
        changed = 0; entered = 0; other = 0;
        if (rst) begin
            m_grp = 0; m_yel = 0; m_ar = 0; m_t = 0;
            for (int i = 0; i < 4; i++) m_pend[i] = 0;
            return;
        end
        if (tk) begin
            if (m_ar) begin
                m_ar = 0; m_grp = next_grp(m_grp); changed = 1; entered = 1;
            end else if (m_yel) begin
                if (m_t + 1 == YT) begin
                    changed = 1; m_yel = 0;
                    if (AR_EN != 0) m_ar = 1;
                    else begin m_grp = next_grp(m_grp); entered = 1; end
                end
            end else begin
                for (int i = 0; i < 4; i++) if (i != m_grp && m_pend[i]) other = 1;
                if (other && ((m_t + 1 >= GMIN && !s[m_grp]) || m_t + 1 >= GMAX)) begin
                    m_yel = 1; changed = 1;
                end
            end
        end
        for (int i = 0; i < 4; i++) if (s[i]) m_pend[i] = 1;
        if (entered) m_pend[m_grp] = 0;
        if (changed) m_t = 0;
        else if (tk && m_t < GMAX) m_t = m_t + 1;
    endtask

    function automatic int exp_light(int g);
        if (!m_ar && m_grp == g) return m_yel ? 1 : 0;
        return 2;
    endfunction

    function automatic int exp_phase();
        if (m_ar) return 8;
        return m_grp * 2 + int'(m_yel);
    endfunction

    task automatic chk(string tag, int obs, int expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic cyc(bit rst, bit tk, bit [3:0] s);
        reset = rst; tick = tk;
        {Tbl, Tb, Tal, Ta} = s;
        @(posedge clk);
        model_step(rst, tk, s);
        #1;
        if (int'(phase) == 8) seen_ar = 1;
        chk("La",    int'(La),    exp_light(0));
        chk("Lal",   int'(Lal),   exp_light(1));
        chk("Lb",    int'(Lb),    exp_light(2));
        chk("Lbl",   int'(Lbl),   exp_light(3));
        chk("phase", int'(phase), exp_phase());
    endtask

    task automatic run_until(int target, bit [3:0] s, output int n);
        n = 0;
        for (int k = 0; k < 200; k++) begin
            cyc(0, 1, s);
            n++;
            if (int'(phase) == target) return;
        end
        n = -1;
    endtask

    int n;
    int prev;
    int got_q[$];
    int exp_q[$];

    initial begin
        reset = 1; tick = 0; Ta = 0; Tal = 0; Tb = 0; Tbl = 0;
        seen_ar = 0;

        // Reset state and idle rest in A green
        cyc(1, 0, 4'b0000);
        chk("rst_phase", int'(phase), 0);
        chk("rst_La", int'(La), 0);
        chk("rst_Lb", int'(Lb), 2);
        repeat (100) cyc(0, 1, 4'b0000);
        chk("idle_phase", int'(phase), 0);

        // Short B demand: A yields at GREEN_MIN, arrow AL skipped
        cyc(1, 0, 4'b0000);
        seen_ar = 0;
        cyc(0, 1, 4'b0000);
        cyc(0, 1, 4'b0100);
        run_until(1, 4'b0000, n);
        chk("s2_min_ticks", n + 2, GMIN);
        run_until(4, 4'b0000, n);
        chk("s2_yel_ticks", n, YT + AR_EN);
        chk("s2_Lb_green", int'(Lb), 0);
        chk("s2_allred_seen", int'(seen_ar), AR_EN);

        // Own sensor held: forced out at GREEN_MAX
        cyc(1, 0, 4'b0000);
        run_until(1, 4'b0101, n);
        chk("s3_max_ticks", n, GMAX);

        // From B green with both arrows requested
        run_until(4, 4'b0100, n);
        chk("s4_in_bgo", int'(phase), 4);
        cyc(0, 1, 4'b1010);
        prev = int'(phase);
        for (int k = 0; k < 150; k++) begin
            cyc(0, 1, 4'b0000);
            if (int'(phase) != prev) begin
                got_q.push_back(int'(phase));
                prev = int'(phase);
            end
        end
        if (AR_EN != 0) exp_q = '{5, 8, 6, 7, 8, 0, 1, 8, 2};
        else            exp_q = '{5, 6, 7, 0, 1, 2};
        chk("s4_seq_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk("s4_seq", got_q[i], exp_q[i]);

        // Reset in the middle of A yellow
        cyc(1, 0, 4'b0000);
        cyc(0, 1, 4'b0100);
        run_until(1, 4'b0000, n);
        cyc(0, 1, 4'b0000);
        cyc(0, 1, 4'b0000);
        chk("s5_pre_phase", int'(phase), 1);
        cyc(1, 1, 4'b1111);
        chk("s5_phase", int'(phase), 0);
        chk("s5_La", int'(La), 0);
        repeat (40) cyc(0, 1, 4'b0000);
        chk("s5_rest", int'(phase), 0);

        // Random traffic, alternating continuous and sparse time-base
        for (int k = 0; k < 3000; k++) begin
            bit tk;
            bit [3:0] s;
            tk = ((k % 400) < 200) ? 1'b1 : ($urandom_range(0, 3) == 0);
            for (int i = 0; i < 4; i++) s[i] = ($urandom_range(0, 15) == 0);
            cyc($urandom_range(0, 499) == 0, tk, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tl_phase_sched.md
Name: tl_phase_sched

Overview:
Timed phase scheduler for a two-road intersection with protected left-turn arrows on both roads. It latches vehicle demand from four loop sensors (A through, A left, B through, B left). It sequences green, yellow and red with minimum and maximum green dwell, and skips left-turn phases that have no demand. It sits above the intersection light drivers and runs from a slow time-base strobe.

Parameters:
GREEN_MIN, 8, minimum green dwell in ticks; range 1..GREEN_MAX
GREEN_MAX, 30, maximum green dwell in ticks while competing demand exists
YELLOW_T, 3, yellow dwell in ticks; must be at least 1
CNT_W, 5, dwell timer width; must satisfy 2^CNT_W > GREEN_MAX

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous reset, active-high
tick  input  1  one-cycle time-base strobe; all timing advances only on cycles with tick=1
Ta  input  1  road A through-traffic sensor (level)
Tal  input  1  road A left-turn sensor (level)
Tb  input  1  road B through-traffic sensor (level)
Tbl  input  1  road B left-turn sensor (level)
La  output  2  road A through light
Lal  output  2  road A left arrow
Lb  output  2  road B through light
Lbl  output  2  road B left arrow
phase  output  3  current state index, for debug

Behaviour:
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10.
- States, with their index on phase:
  - A_GO=0, A_YEL=1, AL_GO=2, AL_YEL=3
  - B_GO=4, B_YEL=5, BL_GO=6, BL_YEL=7
  - ALLRED=8 exists only with the macro; phase widens to 4 bits in that case.
- Outputs are Moore, decoded from the state register. In X_GO, light X is GREEN. In X_YEL, light X is YELLOW. Every other light is RED.
- Reset, synchronous with priority over everything:
  - state=A_GO, dwell timer=0, all pending flags=0
  - La=GREEN; Lal=Lb=Lbl=RED; phase=0
- Demand latches pend_a, pend_al, pend_b, pend_bl:
  - Set on any clk edge where the matching sensor is 1, independent of tick.
  - Cleared on the edge that enters the matching X_GO.
  - If set and clear happen on the same edge, clear wins.
- Dwell timer:
  - Increments on tick and resets to 0 on every state change.
  - Saturates at GREEN_MAX; it never wraps.
- Leaving X_GO (evaluated only on tick cycles; t = timer value before increment). Let other = OR of the pending flags for the other three phases.
  - If t+1 >= GREEN_MIN and other=1 and the own sensor is 0, go to X_YEL.
  - If t+1 >= GREEN_MAX and other=1, go to X_YEL regardless of the own sensor.
  - If other=0, stay in X_GO indefinitely (rest in green).
- Leaving X_YEL: on the tick where t+1 == YELLOW_T, advance to the next GO.
- Next-GO order is cyclic A -> AL -> B -> BL -> A:
  - AL and BL are skipped when their pending flag is 0 at the transition edge.
  - A and B are never skipped.
- Minimum transition latency: GO to YEL takes one clk after the qualifying tick edge. Outputs change in the same cycle the state register updates.
- tick held high continuously is legal; each cycle then counts as one tick.
- Sensor pulses shorter than one clk between ticks are still captured.

Optional Feature:
TL_ALLRED_EN
- Defined:
  - Each X_YEL exits to ALLRED.
  - ALLRED holds all four lights RED for exactly 1 tick, then enters the next GO chosen by the skip rule evaluated at ALLRED exit.
  - phase is 4 bits.
- Undefined: YEL goes directly to the next GO, and phase is 3 bits.

Decomposition:
- Package tl_pkg holds:
  - light encoding constants GREEN, YELLOW, RED
  - state enum/localparams and state width
  - next-phase skip function
- One natural sub-module, tl_dwell_timer: saturating CNT_W-bit counter with tick enable, clear input, and compare outputs for ge_min, ge_max and yel_done.

Test Plan:
1. Reset with all sensors 0 for 100 ticks -> state stays A_GO, La=00, others=10.
2. Tb pulsed 1 clk at tick 2, Ta=0 -> A_YEL entered after tick 8 (GREEN_MIN), B_GO after 3 more ticks, AL skipped, Lb=00.
3. Ta held 1 and Tb=1 from tick 0 -> A_YEL forced exactly at tick 30 (GREEN_MAX).
4. In B_GO with Tal=1 and Tbl=1, Tb=0 -> sequence B_YEL, BL_GO, BL_YEL, A_GO, A_YEL, AL_GO; each pending flag clears on entry to its GO.
5. reset asserted mid-A_YEL (timer=2) -> next edge: A_GO, timer=0, pending cleared, La=00.
6. With TL_ALLRED_EN defined, scenario 2 -> an ALLRED cycle of 1 tick with all lights 10 between A_YEL and B_GO.
